lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- RV32I load/store initiator that drives the single-port data memory request interface (mem_en/mem_addr/mem_wdata/mem_wen in; mem_rdata/mem_rvld back).
- Takes one byte-addressed load/store from the execute stage and generates the word address, byte strobes and lane-replicated write data.
- Waits for the memory's registered read return, then extracts and sign- or zero-extends the loaded data.
- Flags illegal, misaligned, out-of-range and timed-out accesses. One transaction outstanding at a time.

Parameters:
- DATA_WIDTH, 32, data bus width
- BYTE_WIDTH, 8, strobe granularity
- STRB_WIDTH, DATA_WIDTH/BYTE_WIDTH, byte-enable width
- ADDR_WIDTH, 10, memory word-address width
- TIMEOUT, 16, maximum cycles spent in RD_WAIT before an error response

Ports:
- CLK input 1: clock; all logic on the rising edge
- RSTN input 1: asynchronous active-low reset
- req_valid input 1: request present
- req_ready output 1: block can accept a request
- req_we input 1: 1 = store, 0 = load
- req_funct3 input 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr input 32: byte address
- req_wdata input DATA_WIDTH: store data, right-aligned
- rsp_valid output 1: one-cycle response pulse
- rsp_err output 1: error qualifier, valid with rsp_valid
- rsp_rdata output DATA_WIDTH: extended load data, valid with rsp_valid
- mem_en output 1: memory access enable
- mem_addr output ADDR_WIDTH: word address = addr_q[ADDR_WIDTH+1:2]
- mem_wdata output DATA_WIDTH: lane-replicated store data
- mem_wen output STRB_WIDTH: byte write enables; all zero = read
- mem_rdata input DATA_WIDTH: read data from memory
- mem_rvld input 1: read data valid, one cycle after a read access

Behaviour:
- Reset: state IDLE; all request registers, rsp_rdata, rsp_err and the timeout counter are 0. rsp_valid=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, req_ready=1.
- Async reset mid-transaction returns to IDLE immediately; mem_en and rsp_valid drop with RSTN; nothing is replayed.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- Memory-side outputs are decoded from state plus registered fields only. They are non-zero only in ISSUE; zero in all other states.
- IDLE:
  - req_ready=1.
  - On req_valid (accept cycle T), latch we, funct3, addr and wdata.
  - Error check, with any failure going to RESP with err=1:
    - illegal funct3: load 011/110/111, store any value above 010;
    - misaligned: halfword with addr[0]=1, word with addr[1:0]!=0;
    - out of range: addr[31:ADDR_WIDTH+2] != 0.
  - Otherwise go to ISSUE.
- ISSUE (cycle T+1), mem_en=1:
  - SB: wen = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: wen = 0011 if addr[1]=0, else 1100; wdata = half replicated x2.
  - SW: wen = 1111; wdata = wdata_q.
  - Load: wen = 0000.
  - Store goes to RESP; load goes to RD_WAIT with the counter cleared.
- RD_WAIT:
  - mem_rvld=1: capture the extracted data into rsp_rdata, go to RESP.
    - Byte lane = addr[1:0]; halfword lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Else if cnt == TIMEOUT-1: rsp_rdata=0, err=1, go to RESP.
  - Else cnt++.
- RESP: rsp_valid=1 for exactly one cycle (no backpressure), then IDLE. req_ready=0 in all states except IDLE.
- Latency from accept at T to rsp_valid:
  - error: T+1;
  - store: T+2;
  - load: T+3 with a normal memory;
  - timeout: T+2+TIMEOUT.
- Store responses: rsp_rdata=0, err=0.
- rsp_rdata and rsp_err hold between responses and are meaningful only with rsp_valid.
- mem_rvld outside RD_WAIT is ignored.
- A request held valid while busy is accepted only in the next IDLE cycle. Back-to-back throughput: one load per 4 cycles.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF -> at T+1 mem_en=1, mem_addr=4, wen=1111, wdata=0xDEADBEEF; rsp_valid at T+2, err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF at T+3.
- SB addr 0x13, data 0x000000A5 -> wen=1000, wdata=0xA5A5A5A5. Then LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- SH addr 0x16, data 0x8001 -> mem_addr=5, wen=1100, wdata=0x80018001. Then LH -> 0xFFFF8001; LHU -> 0x00008001; LW 0x14 -> 0x8001xxxx with the low half unchanged.
- LW 0x2, LH 0x1, SW 0x1000 and funct3=011 load -> each gives rsp_valid with err=1 at T+1; mem_en never asserted.
- Memory with mem_rvld tied 0, LW 0x20 -> rsp_valid, err=1, rdata=0 at T+18 (TIMEOUT=16); req_ready=1 the following cycle.
- RSTN pulsed low during RD_WAIT -> mem_en=0, rsp_valid=0 immediately, req_ready=1 after release. A late mem_rvld produces no response. A request held during busy is accepted exactly once.

Source files
------------

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : RV32I load/store initiator for a single-port data memory with a
//            registered read return. Accepts one byte-addressed access at a
//            time. Stores are driven as a word address, byte strobes and
//            lane-replicated data. Loads wait for the memory's read-valid and
//            then return the selected lane, sign- or zero-extended.
//            Illegal, misaligned, out-of-range and timed-out accesses are
//            answered with an error response.
// Ports    : CLK, RSTN (async active-low)
//            req_*  : execute-stage request (valid/ready handshake)
//            rsp_*  : one-cycle response pulse with error flag and load data
//            mem_*  : memory request (en/addr/wdata/wen) and read return
//                     (rdata/rvld)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvld
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_RD_WAIT = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_HALF  = 2 * BYTE_WIDTH;

    logic [1:0]            r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    // Only the bits that can be in range are kept; upper bits are checked
    // at accept time and must be zero for the access to proceed.
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_bad_f3;
    logic                  w_misalign;
    logic                  w_out_range;
    logic                  w_req_err;
    logic [BYTE_WIDTH-1:0] w_byte;
    logic [c_HALF-1:0]     w_half;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);

    // Request legality check, evaluated on the live request in IDLE.
    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        if (req_we) begin
            w_bad_f3 = (req_funct3 > 3'b010);
        end else begin
            w_bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
        w_out_range = |req_addr[31:ADDR_WIDTH+2];
        w_req_err   = w_bad_f3 | w_misalign | w_out_range;
    end

    // Memory-side outputs: decoded from state and registered fields only.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        if (r_state == c_ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = r_addr[ADDR_WIDTH+1:2];
            if (r_we) begin
                case (r_funct3[1:0])
                    2'b00: begin
                        mem_wen   = STRB_WIDTH'(1) << r_addr[1:0];
                        mem_wdata = {STRB_WIDTH{r_wdata[BYTE_WIDTH-1:0]}};
                    end
                    2'b01: begin
                        mem_wen   = r_addr[1] ? {{(STRB_WIDTH/2){1'b1}}, {(STRB_WIDTH/2){1'b0}}}
                                              : {{(STRB_WIDTH/2){1'b0}}, {(STRB_WIDTH/2){1'b1}}};
                        mem_wdata = {(STRB_WIDTH/2){r_wdata[c_HALF-1:0]}};
                    end
                    default: begin
                        mem_wen   = '1;
                        mem_wdata = r_wdata;
                    end
                endcase
            end
        end
    end

    // Lane extraction of the returned word; funct3[2] selects zero-extension.
    always_comb begin
        w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: BYTE_WIDTH];
        w_half = mem_rdata[{r_addr[1], 4'b0000} +: c_HALF];
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{(DATA_WIDTH-BYTE_WIDTH){w_byte[BYTE_WIDTH-1] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load_data = {{(DATA_WIDTH-c_HALF){w_half[c_HALF-1] & ~r_funct3[2]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= c_IDLE;
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[ADDR_WIDTH+1:0];
                        r_wdata  <= req_wdata;
                        if (w_req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            r_state   <= c_RESP;
                        end else begin
                            r_state <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (r_we) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= c_RD_WAIT;
                    end
                end
                c_RD_WAIT: begin
                    if (mem_rvld) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= w_load_data;
                        r_state   <= c_RESP;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    // Response is a single unconditional pulse.
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
